// File: rtl/divider_16bit_if.sv
// Operand/result bundle for the iterative divider.
// Ports: start/dividend/divisor flow master->slave; quotient/remainder/busy/
//        done/div0/ovfl flow slave->master. WIDTH sets operand/result width.
interface divider_16bit_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div0;
   logic             ovfl;

   // Requester side (control unit / testbench).
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div0, ovfl
   );

   // Divider side.
   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div0, ovfl
   );
endinterface

// File: rtl/divider_16bit.sv
// Purpose: iterative restoring divider, one trial subtraction per cycle.
// Latency: done WIDTH+1 cycles after an accepted start; 1 cycle for divide-by-zero.
// Backpressure: start is ignored while busy; start is accepted in IDLE and in the DONE cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport): start/dividend/divisor in,
//        quotient/remainder/busy/done/div0/ovfl out. Results hold until the next accepted start.
// Option: define DIVIDER_SIGNED_EN for two's-complement operands (quotient truncates
//         toward zero, remainder takes dividend sign, ovfl on most-negative / -1).
//         Without it the divider is unsigned and ovfl is tied to 0.
module divider_16bit #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   divider_16bit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;          // partial remainder
   logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] d_q, d_d;          // divisor magnitude
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div0_q, div0_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sh, t;
   logic [WIDTH-1:0] r_next, q_next;

`ifdef DIVIDER_SIGNED_EN
   logic neg_q_q, neg_q_d;              // quotient must be negated at the end
   logic neg_r_q, neg_r_d;              // remainder must be negated at the end
   logic ovf_pend_q, ovf_pend_d;        // most-negative / -1 detected at accept
   logic ovfl_q, ovfl_d;

   assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
   assign bus.ovfl = ovfl_q;
`else
   assign a_mag = bus.dividend;
   assign b_mag = bus.divisor;
   assign bus.ovfl = 1'b0;
`endif

   // One restoring step: shift {R,Q} left, trial-subtract D. R < D always holds,
   // so the shifted R fits in WIDTH+1 bits and t[WIDTH] is a valid sign bit.
   assign sh     = {r_q, q_q[WIDTH-1]};
   assign t      = sh - {1'b0, d_q};
   assign r_next = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
   assign q_next = {q_q[WIDTH-2:0], ~t[WIDTH]};

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div0_d      = div0_q;
`ifdef DIVIDER_SIGNED_EN
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
      ovf_pend_d  = ovf_pend_q;
      ovfl_d      = ovfl_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  // No iterations: canned result straight into DONE.
                  state_d     = ST_DONE;
                  quotient_d  = '1;
                  remainder_d = bus.dividend;
                  div0_d      = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                  ovfl_d      = 1'b0;
`endif
               end else begin
                  state_d = ST_RUN;
                  r_d     = '0;
                  q_d     = a_mag;
                  d_d     = b_mag;
                  cnt_d   = CW'(WIDTH);
                  div0_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                  ovfl_d     = 1'b0;
                  neg_q_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  neg_r_d    = bus.dividend[WIDTH-1];
                  // Magnitude path already yields 0x8000 rem 0 here; only the flag is extra.
                  ovf_pend_d = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                               (bus.divisor == '1);
`endif
               end
            end
         end
         ST_RUN: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d     = ST_DONE;
               quotient_d  = q_next;
               remainder_d = r_next;
`ifdef DIVIDER_SIGNED_EN
               if (neg_q_q) quotient_d  = -q_next;
               if (neg_r_q) remainder_d = -r_next;
               ovfl_d = ovf_pend_q;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div0_q      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         ovf_pend_q  <= 1'b0;
         ovfl_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div0_q      <= div0_d;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
         ovf_pend_q  <= ovf_pend_d;
         ovfl_q      <= ovfl_d;
`endif
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.div0      = div0_q;
endmodule

// File: tb/tb_divider_16bit.sv
// Testbench for divider_16bit: directed cases with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_divider_16bit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   divider_16bit_if #(.WIDTH(16)) bus ();
   divider_16bit #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the operand rules.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic ov);
      int sa;
      int sb;
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (a == 16'h8000 && b == 16'hFFFF) begin
         q = 16'h8000; r = 16'h0000; ov = 1'b1;
      end else begin
         q = 16'(sa / sb); r = 16'(sa % sb); ov = 1'b0;
      end
`else
      sa = int'(a);
      sb = int'(b);
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
      ov = 1'b0;
`endif
   endfunction

   // Model: busy for 16 cycles after acceptance, then a one-cycle done.
   int          m_busy = 0;
   bit          m_done = 1'b0;
   logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_div0 = 1'b0, m_ovfl = 1'b0, p_ovfl = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_div0 = 1'b0; m_ovfl = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_done = 1'b1; m_q = p_q; m_r = p_r; m_ovfl = p_ovfl;
            end
         end else if (bus.start) begin
            if (bus.divisor == 16'h0) begin
               m_done = 1'b1; m_q = 16'hFFFF; m_r = bus.dividend; m_div0 = 1'b1; m_ovfl = 1'b0;
            end else begin
               ref_div(bus.dividend, bus.divisor, p_q, p_r, p_ovfl);
               m_busy = 16; m_div0 = 1'b0; m_ovfl = 1'b0;
            end
         end
      end
   end

   // Compare process, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(bus.busy), 32'(m_busy > 0));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("div0", 32'(bus.div0), 32'(m_div0));
         chk("ovfl", 32'(bus.ovfl), 32'(m_ovfl));
         if (m_busy == 0) begin
            chk("quotient", 32'(bus.quotient), 32'(m_q));
            chk("remainder", 32'(bus.remainder), 32'(m_r));
         end
      end
   end

   // Waits for done; while hold is set, start stays high with operands na/nb.
   task automatic wait_done(input bit hold, input logic [15:0] na, input logic [15:0] nb,
                            output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (hold) begin
            bus.dividend = na; bus.divisor = nb;
         end else begin
            bus.start = 1'b0;
            bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
         end
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout no done within 40 cycles at %0t", $time);
      end
   endtask

   task automatic go(input logic [15:0] a, input logic [15:0] b, input bit hold,
                     input logic [15:0] na, input logic [15:0] nb, output int lat);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      wait_done(hold, na, nb, lat);
   endtask

   initial begin
      int          lat;
      logic [15:0] q, r;
      logic        ov;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

      // Pin the model with hand-computed values.
      ref_div(16'd100, 16'd7, q, r, ov);
      chk("model_100_7_q", 32'(q), 32'd14);
      chk("model_100_7_r", 32'(r), 32'd2);
      ref_div(16'd50, 16'd5, q, r, ov);
      chk("model_50_5_q", 32'(q), 32'd10);

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_quotient", 32'(bus.quotient), 32'h0);
      chk("rst_remainder", 32'(bus.remainder), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;

      // 100 / 7
      go(16'd100, 16'd7, 1'b0, 16'h0, 16'h0, lat);
      chk("lat_100_7", 32'(lat), 32'd17);
      chk("q_100_7", 32'(bus.quotient), 32'd14);
      chk("r_100_7", 32'(bus.remainder), 32'd2);
      chk("div0_100_7", 32'(bus.div0), 32'd0);

      // 0x1234 / 0
      go(16'h1234, 16'h0, 1'b0, 16'h0, 16'h0, lat);
      chk("lat_div0", 32'(lat), 32'd1);
      chk("q_div0", 32'(bus.quotient), 32'hFFFF);
      chk("r_div0", 32'(bus.remainder), 32'h1234);
      chk("flag_div0", 32'(bus.div0), 32'd1);
      chk("busy_div0", 32'(bus.busy), 32'd0);

      // Back-to-back: start held high through RUN and the DONE cycle.
      go(16'hFFFF, 16'h1, 1'b1, 16'd9, 16'd3, lat);
      chk("lat_b2b_1", 32'(lat), 32'd17);
      chk("q_b2b_1", 32'(bus.quotient), 32'hFFFF);
      chk("r_b2b_1", 32'(bus.remainder), 32'h0);
      wait_done(1'b0, 16'h0, 16'h0, lat);
      chk("lat_b2b_2", 32'(lat), 32'd17);
      chk("q_b2b_2", 32'(bus.quotient), 32'd3);
      chk("r_b2b_2", 32'(bus.remainder), 32'd0);

      // Reset in RUN cycle 8, with stray start pulses while busy.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.start = (k % 3 == 0);
         bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
      end
      chk("busy_run8", 32'(bus.busy), 32'd1);
      rst = 1'b1; bus.start = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_q", 32'(bus.quotient), 32'd0);
      chk("abort_r", 32'(bus.remainder), 32'd0);
      chk("abort_div0", 32'(bus.div0), 32'd0);
      chk("abort_ovfl", 32'(bus.ovfl), 32'd0);
      rst = 1'b0;
      go(16'd50, 16'd5, 1'b0, 16'h0, 16'h0, lat);
      chk("lat_50_5", 32'(lat), 32'd17);
      chk("q_50_5", 32'(bus.quotient), 32'd10);

      // Sign handling.
      go(16'hFFF9, 16'd2, 1'b0, 16'h0, 16'h0, lat);
`ifdef DIVIDER_SIGNED_EN
      chk("q_m7_2", 32'(bus.quotient), 32'hFFFD);
      chk("r_m7_2", 32'(bus.remainder), 32'hFFFF);
`else
      chk("q_m7_2", 32'(bus.quotient), 32'h7FFC);
      chk("r_m7_2", 32'(bus.remainder), 32'h0001);
`endif
      go(16'h8000, 16'hFFFF, 1'b0, 16'h0, 16'h0, lat);
`ifdef DIVIDER_SIGNED_EN
      chk("q_ovf", 32'(bus.quotient), 32'h8000);
      chk("r_ovf", 32'(bus.remainder), 32'h0);
      chk("ovfl_ovf", 32'(bus.ovfl), 32'd1);
`else
      chk("q_ovf", 32'(bus.quotient), 32'h0);
      chk("r_ovf", 32'(bus.remainder), 32'h8000);
      chk("ovfl_ovf", 32'(bus.ovfl), 32'd0);
`endif

      // Random traffic, including zero divisors, overflow operands and rare resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.dividend = 16'($urandom);
         case ($urandom_range(0, 7))
            0: bus.divisor = 16'h0;
            1: bus.divisor = 16'hFFFF;
            2: bus.divisor = 16'($urandom_range(1, 15));
            3: begin bus.dividend = 16'h8000; bus.divisor = 16'hFFFF; end
            default: bus.divisor = 16'($urandom);
         endcase
      end
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
